// File: rtl/sort_three_floats_seq.sv
// ---------------------------------------------------------------------------
// sort_three_floats_seq
//
// Purpose
//   Accepts three IEEE-754 words over a valid/ready stream and sorts them
//   with a three-step compare-and-swap network: (r0,r1), (r1,r2), (r0,r1).
//   A single floating-point less-or-equal comparator is shared by all three
//   steps. The words are then emitted smallest first. If any comparison saw
//   a NaN operand, every word of that triple is flagged with down_err. In
//   that case the words still leave as a permutation of the inputs.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   up_valid    in   up_data carries an input word
//   up_ready    out  block accepts an input word (LOAD state only)
//   up_data     in   FLEN-bit input float
//   down_valid  out  down_data / down_err are valid (OUT state only)
//   down_ready  in   consumer accepts the output word
//   down_data   out  FLEN-bit sorted output float
//   down_err    out  current triple had a comparison error
//
// Also contained here:
//   sort_three_floats_cfg_pkg  word-width configuration (FLEN)
//   f_less_or_equal            combinational IEEE-754 a <= b comparator
// ---------------------------------------------------------------------------

package sort_three_floats_cfg_pkg;
  // Word width of the floating-point datapath (FP64).
  localparam int FLEN = 64;
  // Exponent width that matches FLEN.
  localparam int NE   = (FLEN == 32) ? 8 : 11;
endpackage

// ---------------------------------------------------------------------------
// f_less_or_equal
//   res_o = 1 when a <= b under IEEE-754 ordering. -0 and +0 compare equal.
//   A NaN in either operand gives res_o = 0 and err_o = 1.
// Ports
//   a_i, b_i  in   operands
//   res_o     out  a <= b
//   err_o     out  at least one operand is NaN
// ---------------------------------------------------------------------------
module f_less_or_equal
  import sort_three_floats_cfg_pkg::*;
(
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic            res_o,
  output logic            err_o
);

  localparam int NF = FLEN - 1 - NE;

  logic            sign_a;
  logic            sign_b;
  logic [FLEN-2:0] mag_a;
  logic [FLEN-2:0] mag_b;
  logic            nan_a;
  logic            nan_b;
  logic            both_zero;
  logic            ordered_le;

  assign sign_a = a_i[FLEN-1];
  assign sign_b = b_i[FLEN-1];
  assign mag_a  = a_i[FLEN-2:0];
  assign mag_b  = b_i[FLEN-2:0];

  // A NaN has an all-ones exponent and a non-zero fraction.
  assign nan_a = (&a_i[FLEN-2 -: NE]) && (|a_i[NF-1:0]);
  assign nan_b = (&b_i[FLEN-2 -: NE]) && (|b_i[NF-1:0]);

  // The two zeros differ only in sign, so they must count as equal.
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  always_comb begin
    ordered_le = 1'b0;
    if (both_zero) begin
      ordered_le = 1'b1;
    end else if (sign_a != sign_b) begin
      // Mixed signs: a <= b exactly when a is the negative one.
      ordered_le = sign_a;
    end else if (!sign_a) begin
      ordered_le = (mag_a <= mag_b);
    end else begin
      // Both negative: a larger magnitude is the smaller value.
      ordered_le = (mag_a >= mag_b);
    end
  end

  assign err_o = nan_a | nan_b;
  assign res_o = ordered_le & ~err_o;

endmodule

// ---------------------------------------------------------------------------
// sort_three_floats_seq (top)
// ---------------------------------------------------------------------------
module sort_three_floats_seq
  import sort_three_floats_cfg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [FLEN-1:0] up_data,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [FLEN-1:0] down_data,
  output logic            down_err
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CMP_A = 3'd1,
    CMP_B = 3'd2,
    CMP_C = 3'd3,
    OUT   = 3'd4
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [1:0]            in_idx_q;
  logic [1:0]            in_idx_d;
  logic [1:0]            out_idx_q;
  logic [1:0]            out_idx_d;
  logic                  err_acc_q;
  logic                  err_acc_d;
  logic [2:0][FLEN-1:0]  r_q;
  logic [2:0][FLEN-1:0]  r_d;

  // Shared comparator operands and results.
  logic                  cmp_active;
  logic [1:0]            lo_idx;
  logic [1:0]            hi_idx;
  logic [FLEN-1:0]       cmp_a;
  logic [FLEN-1:0]       cmp_b;
  logic                  cmp_res;
  logic                  cmp_err;
  logic                  do_swap;
  logic                  load_xfer;

  // -------------------------------------------------------------------------
  // Operand selection. CMP_B works on (r1,r2); CMP_A and CMP_C work on (r0,r1).
  // -------------------------------------------------------------------------
  assign cmp_active = (state_q == CMP_A) || (state_q == CMP_B) || (state_q == CMP_C);
  assign lo_idx     = (state_q == CMP_B) ? 2'd1 : 2'd0;
  assign hi_idx     = lo_idx + 2'd1;

  always_comb begin
    cmp_a = r_q[0];
    cmp_b = r_q[1];
    if (lo_idx == 2'd1) begin
      cmp_a = r_q[1];
      cmp_b = r_q[2];
    end
  end

  f_less_or_equal u_cmp (
    .a_i   (cmp_a),
    .b_i   (cmp_b),
    .res_o (cmp_res),
    .err_o (cmp_err)
  );

  // Swap only on a strict "greater than" (or an unordered NaN pair). Equal
  // words stay put, so the network keeps equal values in arrival order.
  assign do_swap   = cmp_active && !cmp_res;
  assign load_xfer = (state_q == LOAD) && up_valid;

  // -------------------------------------------------------------------------
  // Register-file next state, one slice per word. A slice is written by a
  // load into its slot, or takes its partner's value during a swap.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_word
      logic load_we;
      logic swap_lo_we;
      logic swap_hi_we;

      assign load_we    = load_xfer && (in_idx_q == 2'(gi));
      assign swap_lo_we = do_swap && (lo_idx == 2'(gi));
      assign swap_hi_we = do_swap && (hi_idx == 2'(gi));

      assign r_d[gi] = load_we    ? up_data :
                       swap_lo_we ? cmp_b   :
                       swap_hi_we ? cmp_a   :
                                    r_q[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control next state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    err_acc_d = err_acc_q;

    unique case (state_q)
      LOAD: begin
        if (up_valid) begin
          if (in_idx_q == 2'd2) begin
            in_idx_d  = 2'd0;
            err_acc_d = 1'b0;     // a fresh triple starts with a clean flag
            state_d   = CMP_A;
          end else begin
            in_idx_d  = in_idx_q + 2'd1;
          end
        end
      end

      CMP_A: begin
        err_acc_d = err_acc_q | cmp_err;
        state_d   = CMP_B;
      end

      CMP_B: begin
        err_acc_d = err_acc_q | cmp_err;
        state_d   = CMP_C;
      end

      CMP_C: begin
        err_acc_d = err_acc_q | cmp_err;
        state_d   = OUT;
      end

      OUT: begin
        if (down_ready) begin
          if (out_idx_q == 2'd2) begin
            out_idx_d = 2'd0;
            state_d   = LOAD;
          end else begin
            out_idx_d = out_idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d   = LOAD;
        in_idx_d  = 2'd0;
        out_idx_d = 2'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      in_idx_q  <= 2'd0;
      out_idx_q <= 2'd0;
      err_acc_q <= 1'b0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      err_acc_q <= err_acc_d;
      r_q       <= r_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. All of them come straight from registers, so they stay stable
  // while the consumer applies backpressure.
  // -------------------------------------------------------------------------
  assign up_ready   = (state_q == LOAD);
  assign down_valid = (state_q == OUT);
  assign down_err   = err_acc_q;

  always_comb begin
    down_data = '0;
    if (state_q == OUT) begin
      unique case (out_idx_q)
        2'd0:    down_data = r_q[0];
        2'd1:    down_data = r_q[1];
        2'd2:    down_data = r_q[2];
        default: down_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_three_floats_seq.sv
// ---------------------------------------------------------------------------
// Testbench for sort_three_floats_seq. It uses a table of directed triples,
// hand-written backpressure and reset sequences, and randomized triples
// checked against a sorting reference model built on real arithmetic.
// ---------------------------------------------------------------------------
module tb_sort_three_floats_seq;
  import sort_three_floats_cfg_pkg::*;

  typedef logic [63:0] w_t;
  typedef w_t trip_t [3];

  typedef struct packed {
    logic [2:0][63:0] din;
    logic [2:0][63:0] dexp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            up_valid;
  logic            up_ready;
  logic [FLEN-1:0] up_data;
  logic            down_valid;
  logic            down_ready;
  logic [FLEN-1:0] down_data;
  logic            down_err;

  int n_vec = 0;
  int n_bad = 0;

  localparam w_t QNAN = 64'h7FF8_0000_0000_0000;

  sort_three_floats_seq dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_err   (down_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  function automatic w_t R(input real x);
    return $realtobits(x);
  endfunction

  function automatic logic [2:0][63:0] mk(input real a, input real b, input real c);
    logic [2:0][63:0] v;
    v[0] = $realtobits(a);
    v[1] = $realtobits(b);
    v[2] = $realtobits(c);
    return v;
  endfunction

  function automatic bit is_nan(input w_t w);
    return (w[62:52] == 11'h7FF) && (w[51:0] != 52'd0);
  endfunction

  // Reference: stable insertion sort on real values.
  function automatic trip_t model_sort(input trip_t v);
    trip_t s;
    w_t    key;
    int    j;
    s = v;
    for (int i = 1; i < 3; i++) begin
      key = s[i];
      j   = i - 1;
      while (j >= 0 && $bitstoreal(s[j]) > $bitstoreal(key)) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = key;
    end
    return s;
  endfunction

  // ---------------------------------------------------------------- drivers
  // Pushes a triple in and collects three words out. The caller must be at
  // posedge+1. lat holds the number of edges between the third input
  // transfer and the first sample of down_valid=1.
  task automatic run_triple(input trip_t din, input bit gaps, output trip_t dout,
                            output logic [2:0] errs, output int lat, output bit ok);
    int ni = 0;
    int no = 0;
    int cyc = 0;
    int since = -1;
    bit in_x;
    bit out_x;
    lat  = -1;
    ok   = 1'b1;
    errs = '0;
    for (int i = 0; i < 3; i++) dout[i] = '0;
    while (no < 3) begin
      if (cyc >= 400) begin
        ok = 1'b0;
        break;
      end
      up_valid   = (ni < 3) && (!gaps || $urandom_range(0, 3) != 0);
      up_data    = (ni < 3) ? din[ni] : '0;
      down_ready = !gaps || ($urandom_range(0, 2) != 0);
      #1;
      if (down_valid && lat < 0) lat = since;
      in_x  = up_valid && up_ready;
      out_x = down_valid && down_ready;
      if (out_x) begin
        dout[no] = down_data;
        errs[no] = down_err;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (since >= 0) since++;
      if (in_x) begin
        ni++;
        if (ni == 3) since = 0;
      end
      if (out_x) no++;
    end
    up_valid   = 1'b0;
    down_ready = 1'b0;
  endtask

  task automatic tmo(input string name, input bit ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: timeout, got no completion required completion", name);
    end
  endtask

  task automatic feed(input w_t w);
    bit done = 1'b0;
    up_valid = 1'b1;
    up_data  = w;
    for (int c = 0; c < 50 && !done; c++) begin
      done = up_ready;
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    tmo("feed", done);
  endtask

  task automatic wait_dv();
    bit done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (down_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    tmo("wait_down_valid", done);
  endtask

  // Checks a collected triple against the model (or the multiset rule for NaN).
  task automatic check_triple(input string tag, input trip_t din, input trip_t dout,
                              input logic [2:0] errs, input bit ok);
    trip_t s;
    bit    any_nan;
    int    ci;
    int    co;
    tmo({tag, "_done"}, ok);
    any_nan = is_nan(din[0]) || is_nan(din[1]) || is_nan(din[2]);
    if (!any_nan) begin
      s = model_sort(din);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s_w%0d", tag, i), dout[i], s[i]);
        chk($sformatf("%s_err%0d", tag, i), 64'(errs[i]), 64'd0);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ci = 0;
        co = 0;
        for (int j = 0; j < 3; j++) begin
          if (din[j] === din[i])  ci++;
          if (dout[j] === din[i]) co++;
        end
        chk($sformatf("%s_perm%0d", tag, i), 64'(co), 64'(ci));
        chk($sformatf("%s_err%0d", tag, i), 64'(errs[i]), 64'd1);
      end
    end
  endtask

  // ---------------------------------------------------------------- test
  vec_t tbl[5];

  initial begin
    trip_t      din;
    trip_t      dout;
    logic [2:0] errs;
    int         lat;
    bit         ok;
    w_t         pool[6];

    tbl[0].din = mk(3.0, 1.0, 2.0);    tbl[0].dexp = mk(1.0, 2.0, 3.0);
    tbl[1].din = mk(2.0, 2.0, 1.0);    tbl[1].dexp = mk(1.0, 2.0, 2.0);
    tbl[2].din = mk(-1.5, 0.0, 7.25);  tbl[2].dexp = mk(-1.5, 0.0, 7.25);
    tbl[3].din = mk(9.0, -4.0, 0.25);  tbl[3].dexp = mk(-4.0, 0.25, 9.0);
    tbl[4].din = mk(5.0, 4.0, 3.0);    tbl[4].dexp = mk(3.0, 4.0, 5.0);

    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    rst        = 1'b0;
    #12;
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_down_valid", 64'(down_valid), 64'd0);
    chk("rst_down_data", down_data, 64'd0);
    chk("rst_down_err", 64'(down_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, no gaps.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 3; i++) din[i] = tbl[v].din[i];
      run_triple(din, 1'b0, dout, errs, lat, ok);
      tmo($sformatf("tbl%0d_done", v), ok);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d_w%0d", v, i), dout[i], tbl[v].dexp[i]);
        chk($sformatf("tbl%0d_err%0d", v, i), 64'(errs[i]), 64'd0);
      end
      if (v == 0) chk("tbl0_latency", 64'(lat), 64'd3);
    end

    // NaN triple.
    din[0] = R(1.0); din[1] = QNAN; din[2] = R(0.5);
    run_triple(din, 1'b0, dout, errs, lat, ok);
    check_triple("nan", din, dout, errs, ok);

    // Backpressure: up_valid stays high throughout and must be ignored.
    feed(R(3.0)); feed(R(1.0)); feed(R(2.0));
    up_valid   = 1'b1;
    up_data    = R(100.0);
    down_ready = 1'b0;
    wait_dv();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_data%0d", c), down_data, R(1.0));
      chk($sformatf("bp_hold_err%0d", c), 64'(down_err), 64'd0);
      chk($sformatf("bp_up_ready%0d", c), 64'(up_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_valid%0d", i), 64'(down_valid), 64'd1);
      chk($sformatf("bp_word%0d", i), down_data, R(1.0 + i));
      @(posedge clk);
      #1;
    end
    down_ready = 1'b0;
    chk("bp_back_to_load", 64'(up_ready), 64'd1);

    // Reset after two inputs.
    feed(R(7.0)); feed(R(8.0));
    #2 rst = 1'b0;
    #1;
    chk("rst1_up_ready", 64'(up_ready), 64'd1);
    chk("rst1_down_valid", 64'(down_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    din[0] = R(9.0); din[1] = R(-4.0); din[2] = R(0.25);
    run_triple(din, 1'b0, dout, errs, lat, ok);
    check_triple("rst1", din, dout, errs, ok);

    // Reset during OUT after one output word.
    feed(R(6.0)); feed(R(5.0)); feed(R(4.0));
    wait_dv();
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst2_up_ready", 64'(up_ready), 64'd1);
    chk("rst2_down_valid", 64'(down_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    din[0] = R(9.0); din[1] = R(-4.0); din[2] = R(0.25);
    run_triple(din, 1'b0, dout, errs, lat, ok);
    check_triple("rst2", din, dout, errs, ok);

    // Random back-to-back triples with gaps; start with a reversed triple.
    din[0] = R(5.0); din[1] = R(4.0); din[2] = R(3.0);
    run_triple(din, 1'b1, dout, errs, lat, ok);
    check_triple("rev", din, dout, errs, ok);

    pool[0] = R(0.0);  pool[1] = 64'h8000_0000_0000_0000; pool[2] = R(-2.5);
    pool[3] = R(1.0);  pool[4] = 64'h7FF0_0000_0000_0000; pool[5] = QNAN;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) din[i] = pool[$urandom_range(0, 5)];
        else                           din[i] = {$urandom, $urandom};
      end
      run_triple(din, 1'b1, dout, errs, lat, ok);
      check_triple($sformatf("rnd%0d", t), din, dout, errs, ok);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
